// File: rtl/guess_pkg.sv
// Shared types and constants for the word-guess round controller.
package guess_pkg;

  localparam int NUM_SLOTS_DEF = 8;
  localparam int CHAR_W_DEF    = 5;
  localparam int MAX_TRIES_DEF = 6;
  localparam int SCAN_DIV_DEF  = 4;

  // Letter codes 0..25 are A..Z; BLANK marks an empty slot for the selector.
  localparam logic [4:0] BLANK      = 5'd27;
  localparam logic [4:0] LETTER_MAX = 5'd25;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    SHOW,
    WIN,
    LOSE
  } state_e;

endpackage

// File: rtl/guess_controller_scan_counter.sv
// Free-running display scan: a clock divider feeding a slot index that wraps.
module scan_counter #(
  parameter int NUM_SLOTS = 8,
  parameter int SCAN_DIV  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [$clog2(NUM_SLOTS)-1:0] counter
);

  localparam int CW = $clog2(NUM_SLOTS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SLOTS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Advance the scan index once per divider wrap, wrapping after the last slot.
  always_comb begin
    div_d = div_q + 1'b1;
    cnt_d = cnt_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Divider and index registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign counter = cnt_q;

endmodule

// File: rtl/guess_controller.sv
// One round of the 8-letter guess game: target latch, letter entry,
// slot-by-slot compare and tries tracking, feeding the display selector.
module guess_controller
  import guess_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int CHAR_W    = CHAR_W_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF,
  parameter int SCAN_DIV  = SCAN_DIV_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_SLOTS*CHAR_W-1:0]       target_word,
  input  logic                              key_valid,
  input  logic [CHAR_W-1:0]                 key_code,
  input  logic                              key_enter,
  input  logic                              key_clear,
  output logic [NUM_SLOTS*CHAR_W-1:0]       guess_word,
  output logic [NUM_SLOTS-1:0]              is_correct,
  output logic                              mode,
  output logic [$clog2(NUM_SLOTS)-1:0]      counter,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left,
  output logic                              busy,
  output logic                              win,
  output logic                              lose
);

  localparam int PW = $clog2(NUM_SLOTS + 1);  // write pointer reaches NUM_SLOTS
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int WW = NUM_SLOTS * CHAR_W;

  localparam logic [PW-1:0]     WPTR_FULL  = PW'(NUM_SLOTS);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(NUM_SLOTS - 1);
  localparam logic [TW-1:0]     TRIES_INIT = TW'(MAX_TRIES);
  localparam logic [CHAR_W-1:0] BLANK_C    = CHAR_W'(BLANK);
  localparam logic [CHAR_W-1:0] LETTER_C   = CHAR_W'(LETTER_MAX);
  localparam logic [WW-1:0]     BLANK_WORD = {NUM_SLOTS{BLANK_C}};

  state_e               state_q, state_d;
  logic [WW-1:0]        target_q, target_d;
  logic [WW-1:0]        guess_q, guess_d;
  logic [NUM_SLOTS-1:0] correct_q, correct_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tries_q, tries_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;

  // Round sequencing: start overrides everything; otherwise each state owns its keys.
  always_comb begin
    // NOTE: every *_d holds its current value first, so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    target_d  = target_q;
    guess_d   = guess_q;
    correct_d = correct_q;
    wptr_d    = wptr_q;
    idx_d     = idx_q;
    tries_d   = tries_q;

    if (start) begin
      state_d   = ENTRY;
      target_d  = target_word;
      guess_d   = BLANK_WORD;
      correct_d = '0;
      wptr_d    = '0;
      idx_d     = '0;
      tries_d   = TRIES_INIT;
    end else begin
      unique case (state_q)
        ENTRY: begin
          if (key_clear) begin
            guess_d = BLANK_WORD;
            wptr_d  = '0;
          end else begin
            // Both decisions look at the pre-edge pointer, so at most one fires.
            if (key_valid && (key_code <= LETTER_C) && (wptr_q < WPTR_FULL)) begin
              guess_d[wptr_q*CHAR_W +: CHAR_W] = key_code;
              wptr_d = wptr_q + 1'b1;
            end
            if (key_enter && (wptr_q == WPTR_FULL)) begin
              idx_d   = '0;
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          correct_d[idx_q] = (guess_q[idx_q*CHAR_W +: CHAR_W] ==
                              target_q[idx_q*CHAR_W +: CHAR_W]);
          if (idx_q == IDX_LAST) begin
            tries_d = tries_q - 1'b1;
            if (&correct_d) begin
              state_d = WIN;
            end else if (tries_d == '0) begin
              state_d = LOSE;
              guess_d = target_q;  // reveal the answer on the display
            end else begin
              state_d = SHOW;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        SHOW: begin
          if (key_enter) begin
            guess_d   = BLANK_WORD;
            correct_d = '0;
            wptr_d    = '0;
            state_d   = ENTRY;
          end
        end
        default: ;  // IDLE, WIN, LOSE wait for start
      endcase
    end

    mode_d = (state_d == SHOW) || (state_d == WIN);
    busy_d = (state_d == CHECK);
    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
  end

  // State, slot and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: slot and target registers are reset too, so the display shows BLANK rather than X after reset.
      state_q   <= IDLE;
      target_q  <= '0;
      guess_q   <= BLANK_WORD;
      correct_q <= '0;
      wptr_q    <= '0;
      idx_q     <= '0;
      tries_q   <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      target_q  <= target_d;
      guess_q   <= guess_d;
      correct_q <= correct_d;
      wptr_q    <= wptr_d;
      idx_q     <= idx_d;
      tries_q   <= tries_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  scan_counter #(
    .NUM_SLOTS(NUM_SLOTS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .counter(counter)
  );

  assign guess_word = guess_q;
  assign is_correct = correct_q;
  assign mode       = mode_q;
  assign tries_left = tries_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_guess_controller.sv
// Randomized bench for guess_controller against a round-level reference model.
module tb_guess_controller;

  localparam int N = 8;
  localparam int W = 5;
  localparam int T = 6;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N*W-1:0] target_word = '0;
  logic           key_valid = 1'b0;
  logic [W-1:0]   key_code = '0;
  logic           key_enter = 1'b0;
  logic           key_clear = 1'b0;
  logic [N*W-1:0] guess_word;
  logic [N-1:0]   is_correct;
  logic           mode;
  logic [2:0]     counter;
  logic [2:0]     tries_left;
  logic           busy;
  logic           win;
  logic           lose;

  always #5 clk = ~clk;

  guess_controller #(.NUM_SLOTS(N), .CHAR_W(W), .MAX_TRIES(T), .SCAN_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_word(target_word),
    .key_valid(key_valid), .key_code(key_code), .key_enter(key_enter),
    .key_clear(key_clear), .guess_word(guess_word), .is_correct(is_correct),
    .mode(mode), .counter(counter), .tries_left(tries_left), .busy(busy),
    .win(win), .lose(lose)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scan model: edges since reset released, divided down and folded onto the slots.
  int scan_cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) scan_cyc <= 0;
    else        scan_cyc <= scan_cyc + 1;
  end

  // Round model kept as letter arrays and a phase with a remaining-check count.
  typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_SHOW, M_WIN, M_LOSE} phase_t;
  phase_t       ph = M_IDLE;
  int           m_guess[N];
  int           m_tgt[N];
  int           m_wptr = 0;
  int           m_tries = 0;
  int           m_remain = 0;
  bit [N-1:0]   m_corr = '0;

  task automatic blank_guess();
    for (int i = 0; i < N; i++) m_guess[i] = 27;
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) begin
      ph = M_IDLE; blank_guess(); m_corr = '0; m_wptr = 0; m_tries = 0;
      for (int i = 0; i < N; i++) m_tgt[i] = 0;
    end else if (start) begin
      for (int i = 0; i < N; i++) m_tgt[i] = int'(target_word[i*W +: W]);
      blank_guess(); m_corr = '0; m_wptr = 0; m_tries = T; ph = M_ENTRY;
    end else begin
      case (ph)
        M_ENTRY: begin
          if (key_clear) begin
            blank_guess(); m_wptr = 0;
          end else begin
            w = m_wptr;
            if (key_valid && int'(key_code) <= 25 && w < N) begin
              m_guess[w] = int'(key_code); m_wptr = w + 1;
            end
            if (key_enter && w == N) begin
              ph = M_CHECK; m_remain = N;
            end
          end
        end
        M_CHECK: begin
          m_remain--;
          if (m_remain == 0) begin
            for (int i = 0; i < N; i++) m_corr[i] = (m_guess[i] == m_tgt[i]);
            m_tries--;
            if (m_corr == '1) ph = M_WIN;
            else if (m_tries == 0) begin
              ph = M_LOSE;
              for (int i = 0; i < N; i++) m_guess[i] = m_tgt[i];
            end else ph = M_SHOW;
          end
        end
        M_SHOW: begin
          if (key_enter) begin
            blank_guess(); m_corr = '0; m_wptr = 0; ph = M_ENTRY;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [N*W-1:0] model_word();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_guess[i]);
    return r;
  endfunction

  task automatic compare_all();
    check("guess_word", guess_word, model_word());
    if (ph != M_CHECK) check("is_correct", is_correct, m_corr);
    check("mode", mode, (ph == M_SHOW) || (ph == M_WIN));
    check("busy", busy, ph == M_CHECK);
    check("win", win, ph == M_WIN);
    check("lose", lose, ph == M_LOSE);
    check("tries_left", tries_left, m_tries);
    check("counter", counter, (scan_cyc / D) % N);
  endtask

  // One clock: inputs already driven, model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    start = 0; key_valid = 0; key_enter = 0; key_clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int code);
    key_valid = 1; key_code = W'(code); tick();
  endtask

  task automatic enter();
    key_enter = 1; tick();
  endtask

  task automatic do_start(input logic [N*W-1:0] t);
    start = 1; target_word = t; tick();
  endtask

  task automatic type_word(input logic [N*W-1:0] w);
    for (int i = 0; i < N; i++) press(int'(w[i*W +: W]));
  endtask

  function automatic logic [N*W-1:0] word_of(input string s);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(s.getc(i) - 8'd65);
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_word(input int hi);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, hi));
    return r;
  endfunction

  // Shift one letter to a different letter, staying inside A..Z.
  function automatic logic [W-1:0] other_letter(input logic [W-1:0] c);
    return (c >= 5'd25) ? 5'd0 : c + 5'd1;
  endfunction

  initial begin
    logic [N*W-1:0] tgt;
    logic [N*W-1:0] gw;
    int busy_cycles;

    @(negedge clk);
    // Reset held for two edges, then idle long enough to see the scan index wrap.
    rst_n = 0;
    idle(2);
    check("rst_guess", guess_word, {N{5'd27}});
    check("rst_counter", counter, 0);
    rst_n = 1;
    idle(4 * N + 2);
    press(3);  // ignored in IDLE
    enter();

    // Full correct guess on GAMEOVER.
    tgt = word_of("GAMEOVER");
    do_start(tgt);
    type_word(tgt);
    enter();
    busy_cycles = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    check("win_busy_cycles", busy_cycles, N);
    check("win_flag", win, 1);
    check("win_mask", is_correct, 8'hFF);
    check("win_tries", tries_left, 5);
    press(1); enter(); idle(2);  // WIN holds

    // Slots 0 and 7 wrong, then continue back to entry.
    tgt = rand_word(25);
    gw = tgt;
    gw[0 +: W]       = other_letter(tgt[0 +: W]);
    gw[7*W +: W]     = other_letter(tgt[7*W +: W]);
    do_start(tgt);
    type_word(gw);
    enter();
    idle(N + 1);
    check("show_mode", mode, 1);
    check("show_mask", is_correct, 8'h7E);
    check("show_tries", tries_left, 5);
    press(4);  // ignored in SHOW
    enter();
    check("show_back_blank", guess_word, {N{5'd27}});

    // Six misses in a row end in LOSE.
    tgt = rand_word(25);
    do_start(tgt);
    for (int g = 0; g < T; g++) begin
      gw = rand_word(25);
      gw[(g % N)*W +: W] = other_letter(tgt[(g % N)*W +: W]);
      type_word(gw);
      enter();
      idle(N + 1);
      if (g < T - 1) enter();
    end
    check("lose_flag", lose, 1);
    check("lose_tries", tries_left, 0);
    check("lose_reveal", guess_word, tgt);
    for (int i = 0; i < 10; i++) begin
      key_valid = 1; key_code = W'($urandom_range(0, 25));
      key_enter = 1'($urandom); key_clear = 1'($urandom);
      tick();
    end

    // Entry corner cases.
    tgt = rand_word(25);
    do_start(tgt);
    press(26);                     // out-of-range code
    for (int i = 0; i < N - 1; i++) press($urandom_range(0, 25));
    enter();                       // wptr = 7, ignored
    key_valid = 1; key_code = tgt[7*W +: W]; key_enter = 1; tick();
    check("kv_ke_stay_entry", busy, 0);
    press(5);                      // ninth letter, ignored
    key_clear = 1; key_valid = 1; key_code = 5'd2; tick();
    check("clear_blank", guess_word, {N{5'd27}});

    // start while the compare is at slot 3.
    type_word(tgt);
    enter();
    idle(3);
    tgt = rand_word(25);
    do_start(tgt);
    check("restart_busy", busy, 0);
    check("restart_tries", tries_left, 6);
    type_word(tgt);
    enter();
    idle(N + 1);
    check("restart_new_target", win, 1);

    // Reset mid-entry.
    do_start(rand_word(25));
    press(1); press(2); press(3);
    rst_n = 0; tick();
    rst_n = 1; idle(3);

    // Random soak over a small alphabet so wins and losses both occur.
    do_start(rand_word(1));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        start = 1; target_word = rand_word(1);
      end
      key_valid = ($urandom_range(0, 2) != 0);
      key_code  = ($urandom_range(0, 15) == 0) ? W'($urandom_range(26, 31)) : W'($urandom_range(0, 1));
      key_enter = ($urandom_range(0, 4) == 0);
      key_clear = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
